// File: rtl/instr_align_buf.sv
// rtl/instr_align_buf.sv - fetch-line alignment buffer feeding aligned instruction slots to the pre-decoder
`timescale 1ns/1ps
module instr_align_buf #(
    parameter int              XLEN      = 32,
    parameter int              BUS_LEN   = 2,
    parameter int              BUF_LINES = 4,
    parameter int              FETCH_LEN = 4,
    parameter int              RVC       = 1,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_vld,
    input  logic [XLEN-1:0]                flush_pc,
    input  logic                           line_vld,
    output logic                           line_rdy,
    input  logic [2*BUS_LEN*16-1:0]        line_data,
    input  logic                           line_err,
    input  logic [$clog2(FETCH_LEN+1)-1:0] core_take,
    output logic [FETCH_LEN*XLEN-1:0]      fetch_instr,
    output logic [FETCH_LEN*XLEN-1:0]      fetch_pc,
    output logic [FETCH_LEN-1:0]           fetch_vld,
    output logic [FETCH_LEN-1:0]           fetch_rvc,
    output logic [FETCH_LEN-1:0]           fetch_err
);

    localparam int LHW = 2*BUS_LEN;                  // halfwords per line
    localparam int H   = BUF_LINES*LHW;              // halfword entries
    localparam int LW  = $clog2(LHW);                // line offset width
    localparam int IW  = $clog2(H);                  // entry index width
    localparam int CW  = $clog2(H+1);                // count width
    localparam int PW  = $clog2(H+2*FETCH_LEN+1);    // slot start width
    localparam int TW  = $clog2(FETCH_LEN+1);        // take width
    localparam logic [PW-1:0] H_P = PW'(H);

    logic [15:0]     r_data [H];
    logic            r_err  [H];
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_head_pc;
    logic [LW-1:0]   r_skip;

    logic [PW-1:0]   w_start [FETCH_LEN+1];
    logic [PW-1:0]   w_cnt_p;
    logic [PW-1:0]   w_cons;
    logic [PW-1:0]   w_app;
    logic [TW-1:0]   w_nv;
    logic [TW-1:0]   w_k;
    logic            w_accept;
    logic [15:0]     w_nd [H];
    logic            w_ne [H];

    assign w_cnt_p  = PW'(r_cnt);
    assign line_rdy = (r_cnt <= CW'(H - LHW));
    assign w_accept = line_vld && line_rdy && !flush_vld;

    // Slot decode: walk the buffer from entry 0, sizing each instruction by its low halfword
    always_comb begin
        logic [PW-1:0] s;
        logic [PW-1:0] s1;
        logic [15:0]   lo;
        logic [15:0]   hi;
        logic          lo_e;
        logic          hi_e;
        logic          lo_in;
        logic          hi_in;
        logic          short_i;
        logic          prev;
        s           = '0;
        s1          = '0;
        lo          = '0;
        hi          = '0;
        lo_e        = 1'b0;
        hi_e        = 1'b0;
        lo_in       = 1'b0;
        hi_in       = 1'b0;
        short_i     = 1'b0;
        prev        = 1'b1;
        fetch_instr = '0;
        fetch_pc    = '0;
        fetch_vld   = '0;
        fetch_rvc   = '0;
        fetch_err   = '0;
        for (int i = 0; i < FETCH_LEN; i++) begin
            w_start[i] = s;
            s1      = s + PW'(1);
            lo_in   = (s < w_cnt_p);
            hi_in   = (s1 < w_cnt_p);
            lo      = (s < H_P)  ? r_data[s[IW-1:0]]  : 16'h0;
            hi      = (s1 < H_P) ? r_data[s1[IW-1:0]] : 16'h0;
            lo_e    = (s < H_P)  ? r_err[s[IW-1:0]]   : 1'b0;
            hi_e    = (s1 < H_P) ? r_err[s1[IW-1:0]]  : 1'b0;
            short_i = (RVC != 0) && (lo[1:0] != 2'b11);
            fetch_instr[i*XLEN +: XLEN] = XLEN'({hi, lo});
            fetch_pc[i*XLEN +: XLEN]    = r_head_pc + (XLEN'(s) << 1);
            if (short_i) begin
                fetch_vld[i] = prev && lo_in;
                fetch_err[i] = prev && lo_in && lo_e;
                s            = s1;
            end else begin
                // a faulted low half is released on its own so the fault is never stalled
                fetch_vld[i] = prev && (hi_in || (lo_in && lo_e));
                fetch_err[i] = prev && (hi_in || (lo_in && lo_e)) && (lo_e || (hi_in && hi_e));
                s            = s + PW'(2);
            end
            fetch_rvc[i] = fetch_vld[i] && short_i;
            prev         = fetch_vld[i];
        end
        w_start[FETCH_LEN] = s;
    end

    // Consume: clamp the take to the valid slots and never remove more than is stored
    always_comb begin
        w_nv = '0;
        for (int i = 0; i < FETCH_LEN; i++) begin
            if (fetch_vld[i]) begin
                w_nv = w_nv + TW'(1);
            end
        end
        w_k    = (core_take < w_nv) ? core_take : w_nv;
        w_cons = w_start[w_k];
        if (w_cons > w_cnt_p) begin
            w_cons = w_cnt_p;
        end
        w_app = w_accept ? (PW'(LHW) - PW'(r_skip)) : '0;
    end

    // Next storage image: shift out consumed halfwords, then append the line after the survivors
    always_comb begin
        logic [PW-1:0] jp;
        logic [PW-1:0] src;
        logic [PW-1:0] base_p;
        logic [PW-1:0] idx;
        jp     = '0;
        src    = '0;
        idx    = '0;
        base_p = w_cnt_p - w_cons;
        for (int j = 0; j < H; j++) begin
            jp      = PW'(j);
            src     = jp + w_cons;
            w_nd[j] = r_data[j];
            w_ne[j] = r_err[j];
            if (src < w_cnt_p) begin
                w_nd[j] = r_data[src[IW-1:0]];
                w_ne[j] = r_err[src[IW-1:0]];
            end else if (w_accept && (jp >= base_p) && (jp < base_p + w_app)) begin
                idx     = jp - base_p + PW'(r_skip);
                w_nd[j] = line_data[idx[LW-1:0]*16 +: 16];
                w_ne[j] = line_err;
            end
        end
    end

    // Halfword data needs no reset: entries at or above cnt are never presented
    always_ff @(posedge clk) begin
        for (int j = 0; j < H; j++) begin
            r_data[j] <= w_nd[j];
        end
    end

    // Control state and fault tags; flush overrides consume and append
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_head_pc <= RESET_PC;
            r_skip    <= '0;
            for (int j = 0; j < H; j++) begin
                r_err[j] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < H; j++) begin
                r_err[j] <= w_ne[j];
            end
            if (flush_vld) begin
                r_cnt     <= '0;
                r_head_pc <= flush_pc;
                r_skip    <= flush_pc[LW:1];
            end else begin
                r_cnt     <= r_cnt - CW'(w_cons) + CW'(w_app);
                r_head_pc <= r_head_pc + (XLEN'(w_cons) << 1);
                if (w_accept) begin
                    r_skip <= '0;
                end
            end
        end
    end

    a_take_legal: assert property (@(posedge clk) disable iff (!rst)
        flush_vld || (core_take <= w_nv));

    generate
        if (RVC == 0) begin : g_no_rvc
            a_flush_word: assert property (@(posedge clk) disable iff (!rst)
                !(flush_vld && flush_pc[1]));
        end
    endgenerate

endmodule
